spi_hid_io: RTL
===============

SPI_HID_IO -- requirements
Module: spi_hid_io

Interface
REQ-001 SHALL have parameter NUM_JOY, default 4, number of joystick channels (1..8).
REQ-002 SHALL have parameter JOY_W, default 16, bits per joystick (8, 16, 24 or 32).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, event FIFO entries (power of 2, 4..64).
REQ-004 SHALL have parameter CORE_ID, default 8'hA4, byte returned on MISO during command byte.
REQ-005 SHALL have ports, one per line: name direction width meaning.
- clk_sys  in  1  the single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- SPI_CLK  in  1  SPI clock from IO controller, asynchronous, idle low.
- SPI_SS_IO  in  1  slave select, active low.
- SPI_MOSI  in  1  serial data in, MSB first.
- SPI_MISO  out  1  serial data out, MSB first.
- SPI_MISO_OE  out  1  MISO output enable, high while selected.
- JOY  out  NUM_JOY*JOY_W  joystick n at bits [n*JOY_W +: JOY_W].
- BUTTONS  out  2  buttons.
- SWITCHES  out  2  switches.
- CONF  out  4  configuration bits.
- MOUSE_BUTTONS  out  3  mouse button state.
- EV_VALID  out  1  event FIFO not empty.
- EV_READY  in  1  consumer pops head when EV_VALID and EV_READY.
- EV_TYPE  out  2  head type: 0 mouse X, 1 mouse Y, 2 keycode, 3 OSD key.
- EV_DATA  out  8  head data.
- EV_OVERFLOW  out  1  sticky: event dropped while FIFO full.
- EV_CLR  in  1  clears EV_OVERFLOW.
- STATUS  out  32  status word from command 0x1E.

Function
REQ-006 SHALL pass SPI_CLK, SPI_SS_IO, SPI_MOSI through 2-FF synchronisers; SCK edges detected in clk_sys; clk_sys >= 6x SPI_CLK.
REQ-007 SHALL sample MOSI on each synchronised SCK rising edge while SS low; 8 bits form a byte, MSB first.
REQ-008 SHALL, on synchronised SS rising edge, discard any partial byte and clear bit and byte counters.
REQ-009 SHALL count bytes per transfer from 0, saturating at 255; byte 0 is the command.
REQ-010 SHALL drive SPI_MISO from CORE_ID bit (7-bit_cnt) on each synchronised SCK falling edge during byte 0, then 0; SPI_MISO_OE = synchronised SS low.
REQ-011 SHALL process each completed byte in the clk_sys cycle after its 8th rising edge is detected.
REQ-012 Command 0x01: byte 1 -> {CONF, SWITCHES, BUTTONS}; later bytes ignored.
REQ-013 Command 0x60+n, n < NUM_JOY: byte k (1..JOY_W/8) -> joystick n bits [(k-1)*8 +: 8]; excess bytes ignored; n >= NUM_JOY ignored entirely.
REQ-014 Command 0x04: byte 1 pushes {0,dx}, byte 2 pushes {1,dy}, byte 3 -> MOUSE_BUTTONS[2:0]; later bytes ignored.
REQ-015 Commands 0x05 / 0x06: every data byte pushes type 2 / type 3 respectively.
REQ-016 Unknown commands SHALL be ignored with no output change.
REQ-017 FIFO SHALL be first-word-fall-through; EV_TYPE/EV_DATA valid whenever EV_VALID.
REQ-018 Push when full SHALL be dropped and set EV_OVERFLOW, unless a pop occurs the same cycle, in which case both succeed.
REQ-019 Push and pop same cycle when not full/empty SHALL both succeed, occupancy unchanged; pop when empty ignored.
REQ-020 EV_CLR SHALL clear EV_OVERFLOW; a simultaneous overflow SHALL win (flag stays set).

Reset
REQ-021 reset SHALL clear JOY, BUTTONS, SWITCHES, CONF, MOUSE_BUTTONS, STATUS, EV_OVERFLOW, FIFO pointers (EV_VALID=0), counters; SPI_MISO=0, SPI_MISO_OE=0.
REQ-022 After reset deasserts mid-transfer, bytes SHALL be ignored until SS has been seen high.

Configuration
REQ-023 Macro SPI_HID_IO_STATUS_EN defined: command 0x1E bytes 1..4 -> STATUS [7:0],[15:8],[23:16],[31:24]; a transfer ending early leaves unwritten bytes unchanged.
REQ-024 Macro undefined: 0x1E treated as unknown, STATUS tied to 0, no status register present.

Verification
REQ-025 Send 0x01,0xB5 -> BUTTONS=01, SWITCHES=01, CONF=1011; MISO over byte 0 = 0xA4.
REQ-026 Send 0x61,0x34,0x12,0xFF (JOY_W=16) -> joystick 1 = 0x1234, others 0; 0x67 with NUM_JOY=4 -> no change.
REQ-027 Send 0x04,0x05,0xFB,0x03 -> FIFO {0,0x05},{1,0xFB}; MOUSE_BUTTONS=3'b011.
REQ-028 EV_READY=0, send 0x05 plus FIFO_DEPTH+1 keycodes -> FIFO full, EV_OVERFLOW=1, first key at head; EV_CLR -> 0.
REQ-029 Raise SS after 4 bits of a 0x01 data byte -> BUTTONS unchanged; next transfer decodes correctly.
REQ-030 With SPI_HID_IO_STATUS_EN, send 0x1E,0x78,0x56,0x34,0x12 -> STATUS=0x12345678; without it STATUS=0.

Source files
------------

// File: rtl/spi_hid_io.sv
// spi_hid_io: SPI slave that decodes IO-controller commands into joystick,
// button/switch/config, mouse state and an event FIFO (mouse deltas, keys).
// Optional build macro SPI_HID_IO_STATUS_EN adds the 32-bit status register
// written by command 0x1E; without it STATUS is tied to zero.
module spi_hid_io #(
  parameter int unsigned NUM_JOY    = 4,
  parameter int unsigned JOY_W      = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  CORE_ID    = 8'hA4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     SPI_CLK,
  input  logic                     SPI_SS_IO,
  input  logic                     SPI_MOSI,
  output logic                     SPI_MISO,
  output logic                     SPI_MISO_OE,
  output logic [NUM_JOY*JOY_W-1:0] JOY,
  output logic [1:0]               BUTTONS,
  output logic [1:0]               SWITCHES,
  output logic [3:0]               CONF,
  output logic [2:0]               MOUSE_BUTTONS,
  output logic                     EV_VALID,
  input  logic                     EV_READY,
  output logic [1:0]               EV_TYPE,
  output logic [7:0]               EV_DATA,
  output logic                     EV_OVERFLOW,
  input  logic                     EV_CLR,
  output logic [31:0]              STATUS
);

  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned JOY_BYTES = JOY_W / 8;

  // ---------------------------------------------------------------------
  // Input synchronisers and SCK edge detection
  // ---------------------------------------------------------------------
  logic [1:0] sck_sync, ss_sync, mosi_sync;
  logic       sck_d;
  logic       sck, ss, mosi, sck_rise, sck_fall;

  // Free-running 2-FF synchronisers so the SS level is trustworthy right after reset
  always_ff @(posedge clk_sys) begin
    sck_sync  <= {sck_sync[0], SPI_CLK};
    ss_sync   <= {ss_sync[0], SPI_SS_IO};
    mosi_sync <= {mosi_sync[0], SPI_MOSI};
    sck_d     <= sck_sync[1];
  end

  assign sck      = sck_sync[1];
  assign ss       = ss_sync[1];
  assign mosi     = mosi_sync[1];
  assign sck_rise = sck & ~sck_d;
  assign sck_fall = ~sck & sck_d;

  // ---------------------------------------------------------------------
  // Byte assembly
  // ---------------------------------------------------------------------
  logic       armed;
  logic [2:0] bit_cnt;
  logic [7:0] byte_cnt;
  logic [6:0] shift;
  logic       byte_done;
  logic [7:0] byte_data;
  logic [7:0] byte_idx;

  // Shift MOSI on SCK rise; deselect drops any partial byte and rearms
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      armed     <= 1'b0;
      bit_cnt   <= 3'd0;
      byte_cnt  <= 8'd0;
      shift     <= 7'd0;
      byte_done <= 1'b0;
      byte_data <= 8'd0;
      byte_idx  <= 8'd0;
    end else begin
      byte_done <= 1'b0;
      if (ss) begin
        armed    <= 1'b1;
        bit_cnt  <= 3'd0;
        byte_cnt <= 8'd0;
      end else if (armed && sck_rise) begin
        shift   <= {shift[5:0], mosi};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_done <= 1'b1;
          byte_data <= {shift, mosi};
          byte_idx  <= byte_cnt;
          if (byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 8'd1;
        end
      end
    end
  end

  // MISO: core id during the command byte (bit 7 preloaded while idle), then zero
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      SPI_MISO    <= 1'b0;
      SPI_MISO_OE <= 1'b0;
    end else begin
      SPI_MISO_OE <= ~ss;
      if (ss)
        SPI_MISO <= CORE_ID[7];
      else if (sck_fall)
        SPI_MISO <= (byte_cnt == 8'd0) ? CORE_ID[3'd7 - bit_cnt] : 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Command decode
  // ---------------------------------------------------------------------
  logic [7:0] cmd;
  logic       is_joy;
  logic       push;
  logic [1:0] push_type;

  assign is_joy = (cmd[7:3] == 5'b01100);

  // Event pushes generated by completed data bytes
  always_comb begin
    push      = 1'b0;
    push_type = 2'd0;
    if (byte_done && byte_idx != 8'd0) begin
      case (cmd)
        8'h04: begin
          if (byte_idx == 8'd1) begin
            push      = 1'b1;
            push_type = 2'd0;
          end else if (byte_idx == 8'd2) begin
            push      = 1'b1;
            push_type = 2'd1;
          end
        end
        8'h05: begin
          push      = 1'b1;
          push_type = 2'd2;
        end
        8'h06: begin
          push      = 1'b1;
          push_type = 2'd3;
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_HID_IO_STATUS_EN
  logic [31:0] status_r;
  assign STATUS = status_r;
`else
  assign STATUS = 32'd0;
`endif

  // Latch command byte and apply data bytes to the state registers
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cmd           <= 8'd0;
      JOY           <= '0;
      BUTTONS       <= 2'd0;
      SWITCHES      <= 2'd0;
      CONF          <= 4'd0;
      MOUSE_BUTTONS <= 3'd0;
`ifdef SPI_HID_IO_STATUS_EN
      status_r      <= 32'd0;
`endif
    end else if (byte_done) begin
      if (byte_idx == 8'd0) begin
        cmd <= byte_data;
      end else begin
        if (cmd == 8'h01 && byte_idx == 8'd1)
          {CONF, SWITCHES, BUTTONS} <= byte_data;
        if (cmd == 8'h04 && byte_idx == 8'd3)
          MOUSE_BUTTONS <= byte_data[2:0];
        for (int n = 0; n < NUM_JOY; n++) begin
          for (int k = 0; k < JOY_BYTES; k++) begin
            if (is_joy && cmd[2:0] == 3'(n) && byte_idx == 8'(k + 1))
              JOY[n*JOY_W + k*8 +: 8] <= byte_data;
          end
        end
`ifdef SPI_HID_IO_STATUS_EN
        if (cmd == 8'h1E) begin
          case (byte_idx)
            8'd1: status_r[7:0]   <= byte_data;
            8'd2: status_r[15:8]  <= byte_data;
            8'd3: status_r[23:16] <= byte_data;
            8'd4: status_r[31:24] <= byte_data;
            default: ;
          endcase
        end
`endif
      end
    end
  end

  // ---------------------------------------------------------------------
  // Event FIFO (first-word-fall-through)
  // ---------------------------------------------------------------------
  logic [9:0]       mem [FIFO_DEPTH];
  logic [CNT_W-1:0] wr_ptr, rd_ptr, occ;
  logic             full, pop, push_ok;

  assign occ      = wr_ptr - rd_ptr;
  assign full     = (occ == CNT_W'(FIFO_DEPTH));
  assign EV_VALID = (wr_ptr != rd_ptr);
  assign pop      = EV_VALID & EV_READY;
  assign push_ok  = push & (~full | pop);
  assign {EV_TYPE, EV_DATA} = mem[rd_ptr[PTR_W-1:0]];

  // Pointer update and sticky overflow (a new overflow beats EV_CLR)
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      EV_OVERFLOW <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + CNT_W'(1);
      if (pop)     rd_ptr <= rd_ptr + CNT_W'(1);
      if (push && full && !pop)
        EV_OVERFLOW <= 1'b1;
      else if (EV_CLR)
        EV_OVERFLOW <= 1'b0;
    end
  end

  // FIFO storage write
  always_ff @(posedge clk_sys) begin
    if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= {push_type, byte_data};
  end

endmodule
